// File: rtl/pio_arb_pkg.sv
// Shared types and helpers for the PIO write arbiter.
package pio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int PIO_DATA_W = 32;
    localparam int PIO_ADDR_W = 2;

    // Index width that never collapses to zero bits for a single requester.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping modulo N.
module rr_priority_picker
    import pio_arb_pkg::*;
#(
    parameter int N = 2,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    int best;
    int d;

    // d is the search distance from last_grant+1; the smallest requesting distance wins.
    always_comb begin
        best  = N;
        d     = 0;
        idx   = '0;
        any   = 1'b0;
        grant = '0;
        for (int i = 0; i < N; i++) begin
            d = (i + N - 1 - int'(last_grant)) % N;
            if (req[i] && (d < best)) begin
                best = d;
                idx  = W'(i);
                any  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            grant[i] = any && (idx == W'(i));
        end
    end

endmodule

// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM PIO output slave between NUM_REQ
// requesters, one write per grant with an optional idle gap after each strobe.
//
// state | meaning
// IDLE  | waiting for a valid request; winner accepted combinationally
// WRITE | single-cycle chipselect/write_n strobe to the PIO
// GAP   | idle spacing so polling software sees every value
module pio_write_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 0,
    parameter int DATA_W     = PIO_DATA_W,
    parameter int ADDR_W     = PIO_ADDR_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]         req_address,
    input  logic [NUM_REQ*DATA_W-1:0]         req_writedata,
    output logic                              pio_chipselect,
    output logic                              pio_write_n,
    output logic [ADDR_W-1:0]                 pio_address,
    output logic [DATA_W-1:0]                 pio_writedata,
    output logic [clog2_min1(NUM_REQ)-1:0]    grant_id,
    output logic                              busy
);

    localparam int GW = clog2_min1(NUM_REQ);

    arb_state_t           state, state_next;
    logic [7:0]           gap_cnt, gap_next;
    logic [GW-1:0]        last_grant;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [GW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 accept;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;

    rr_priority_picker #(.N(NUM_REQ), .W(GW)) u_picker (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_addr = req_address[i*ADDR_W +: ADDR_W];
                sel_data = req_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_next     = state;
        gap_next       = gap_cnt;
        accept         = 1'b0;
        req_ready      = '0;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                req_ready = pick_grant;
                if (pick_any) begin
                    accept     = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                if (GAP_CYCLES == 0) begin
                    state_next = IDLE;
                end else begin
                    state_next = GAP;
                    gap_next   = 8'(GAP_CYCLES);
                end
            end
            GAP: begin
                gap_next = gap_cnt - 8'd1;
                if (gap_cnt == 8'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                gap_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            last_grant    <= GW'(NUM_REQ - 1);
            grant_id      <= '0;
            pio_address   <= '0;
            pio_writedata <= '0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_next;
            if (accept) begin
                last_grant    <= pick_idx;
                grant_id      <= pick_idx;
                pio_address   <= sel_addr;
                pio_writedata <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Directed bench: instance a runs with no gap, instance b with a 3-cycle gap.
module tb_pio_write_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        reset_a, reset_b;
    logic [1:0]  valid_a, valid_b, ready_a, ready_b;
    logic [3:0]  addr_a, addr_b;
    logic [63:0] data_a, data_b;
    logic        cs_a, cs_b, wn_a, wn_b, busy_a, busy_b;
    logic [1:0]  paddr_a, paddr_b;
    logic [31:0] pdata_a, pdata_b;
    logic [0:0]  gid_a, gid_b;

    pio_write_arbiter #(.NUM_REQ(2), .GAP_CYCLES(0), .DATA_W(32), .ADDR_W(2)) dut_a (
        .clk(clk), .reset(reset_a), .req_valid(valid_a), .req_ready(ready_a),
        .req_address(addr_a), .req_writedata(data_a),
        .pio_chipselect(cs_a), .pio_write_n(wn_a), .pio_address(paddr_a),
        .pio_writedata(pdata_a), .grant_id(gid_a), .busy(busy_a)
    );

    pio_write_arbiter #(.NUM_REQ(2), .GAP_CYCLES(3), .DATA_W(32), .ADDR_W(2)) dut_b (
        .clk(clk), .reset(reset_b), .req_valid(valid_b), .req_ready(ready_b),
        .req_address(addr_b), .req_writedata(data_b),
        .pio_chipselect(cs_b), .pio_write_n(wn_b), .pio_address(paddr_b),
        .pio_writedata(pdata_b), .grant_id(gid_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [1:0]  exp_r;
        logic [31:0] exp_d;
        int          ph;

        reset_a = 1'b1; reset_b = 1'b1;
        valid_a = '0;   valid_b = '0;
        addr_a  = '0;   addr_b  = '0;
        data_a  = '0;   data_b  = '0;
        repeat (2) @(negedge clk);
        reset_a = 1'b0; reset_b = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_cs", 32'(cs_a), 32'd0);
            check("idle_wn", 32'(wn_a), 32'd1);
            check("idle_busy", 32'(busy_a), 32'd0);
            check("idle_ready", 32'(ready_a), 32'd0);
            check("idle_data", pdata_a, 32'd0);
        end

        // Single write from requester 0
        @(negedge clk);
        valid_a = 2'b01; addr_a = 4'b0000; data_a = {32'h0, 32'hDEADBEEF};
        #1 check("single_ready", 32'(ready_a), 32'd1);
        @(negedge clk);
        valid_a = 2'b00;
        check("single_cs", 32'(cs_a), 32'd1);
        check("single_wn", 32'(wn_a), 32'd0);
        check("single_addr", 32'(paddr_a), 32'd0);
        check("single_data", pdata_a, 32'hDEADBEEF);
        check("single_gid", 32'(gid_a), 32'd0);
        check("single_busy", 32'(busy_a), 32'd1);
        check("single_ready_w", 32'(ready_a), 32'd0);
        @(negedge clk);
        check("single_cs_end", 32'(cs_a), 32'd0);
        check("single_wn_end", 32'(wn_a), 32'd1);
        check("single_busy_end", 32'(busy_a), 32'd0);
        check("single_data_hold", pdata_a, 32'hDEADBEEF);
        @(negedge clk);
        check("single_no_repeat", 32'(cs_a), 32'd0);

        // Fresh pointer, then both requesters valid: order 0,1,0,1
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        valid_a = 2'b11; addr_a = 4'b10_01; data_a = {32'h2, 32'h1};
        for (int k = 0; k < 4; k++) begin
            exp_r = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (k % 2 == 0) ? 32'h1 : 32'h2;
            #1 check("rr_ready", 32'(ready_a), 32'(exp_r));
            check("rr_cs_idle", 32'(cs_a), 32'd0);
            @(negedge clk);
            check("rr_cs", 32'(cs_a), 32'd1);
            check("rr_data", pdata_a, exp_d);
            check("rr_addr", 32'(paddr_a), (k % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_gid", 32'(gid_a), 32'(k % 2));
            check("rr_ready_w", 32'(ready_a), 32'd0);
            @(negedge clk);
        end

        // Reset asserted during the WRITE cycle drops the write
        #1 check("rst_pre_ready", 32'(ready_a), 32'd1);
        @(negedge clk);
        check("rst_in_write", 32'(cs_a), 32'd1);
        reset_a = 1'b1; valid_a = 2'b00;
        @(negedge clk);
        check("rst_cs", 32'(cs_a), 32'd0);
        check("rst_wn", 32'(wn_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_addr", 32'(paddr_a), 32'd0);
        check("rst_data", pdata_a, 32'd0);
        check("rst_gid", 32'(gid_a), 32'd0);
        check("rst_ready", 32'(ready_a), 32'd0);
        reset_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_replay_cs", 32'(cs_a), 32'd0);
            check("rst_no_replay_busy", 32'(busy_a), 32'd0);
        end

        // Gap of 3: requester 1 held valid, strobes every 5 cycles
        valid_b = 2'b10; addr_b = 4'b11_00; data_b = {32'hA5A50001, 32'h0};
        #1 check("gap_ready0", 32'(ready_b), 32'd2);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            ph = j % 5;
            #1;
            check("gap_cs", 32'(cs_b), (ph == 1) ? 32'd1 : 32'd0);
            check("gap_wn", 32'(wn_b), (ph == 1) ? 32'd0 : 32'd1);
            check("gap_busy", 32'(busy_b), (ph != 0) ? 32'd1 : 32'd0);
            check("gap_ready", 32'(ready_b), (ph == 0) ? 32'd2 : 32'd0);
            check("gap_data", pdata_b, 32'hA5A50001);
            check("gap_gid", 32'(gid_b), 32'd1);
        end

        // Requester 0 pulses valid only while the arbiter sits in GAP
        @(negedge clk);
        valid_b = 2'b00;
        check("drop_cs", 32'(cs_b), 32'd1);
        @(negedge clk);
        valid_b = 2'b01; addr_b = 4'b00_10; data_b = {32'h0, 32'h12345678};
        #1 check("drop_ready_gap", 32'(ready_b), 32'd0);
        check("drop_busy_gap", 32'(busy_b), 32'd1);
        @(negedge clk);
        valid_b = 2'b00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("drop_no_cs", 32'(cs_b), 32'd0);
            check("drop_no_ready", 32'(ready_b), 32'd0);
            check("drop_data_hold", pdata_b, 32'hA5A50001);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
